// File: rtl/tiled_frame_buffer.sv
// Double-buffered tile store between the pixel producer and the VGA scan path.
// The producer fills the back buffer; buffers swap only at a frame boundary after the producer signals frame completion.
module tiled_frame_buffer #(
    parameter  int HPIXELS    = 640,
    parameter  int VPIXELS    = 480,
    parameter  int BLOCK_SIZE = 20,
    parameter  int DATA_W     = 8,
    localparam int COLS       = HPIXELS / BLOCK_SIZE,
    localparam int ROWS       = VPIXELS / BLOCK_SIZE,
    localparam int DEPTH      = COLS * ROWS,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_frame_done,
    output logic              wr_ready,
    output logic [DATA_W-1:0] pixel_data_out,
    output logic              pixel_valid,
    output logic              front_sel,
    output logic              frame_swapped,
    output logic [15:0]       repeat_count
);

    localparam logic [0:0] FILL    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [9:0]  H_LIM    = 10'(HPIXELS);
    localparam logic [9:0]  V_LIM    = 10'(VPIXELS);
    localparam logic [9:0]  TILE     = 10'(BLOCK_SIZE);
    localparam logic [19:0] COLS_W   = 20'(COLS);

    logic [0:0]        state;
    logic              boundary;
    logic              front_next;
    logic              wr_ok;
    logic              we0;
    logic              we1;

    logic              visible;
    logic [9:0]        tile_col;
    logic [9:0]        tile_row;
    logic [19:0]       tile_lin;
    logic [ADDR_W-1:0] rd_addr_next;

    logic [ADDR_W-1:0] rd_addr_q;
    logic              vis_q;
    logic              sel_q;
    logic              vis_q1;
    logic              sel_q1;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    assign boundary = (hc == 10'd0) && (vc == 10'd0);
    assign wr_ready = (state == FILL);
    assign wr_ok    = (state == FILL) && wr_en && (32'(wr_addr) < 32'(DEPTH));
    assign we0      = wr_ok && front_sel;
    assign we1      = wr_ok && !front_sel;

    always_comb begin
        front_next = front_sel;
        if ((state == PENDING) && boundary)
            front_next = ~front_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            front_sel     <= 1'b0;
            frame_swapped <= 1'b0;
            repeat_count  <= '0;
        end else begin
            frame_swapped <= 1'b0;
            front_sel     <= front_next;
            case (state)
                FILL: begin
                    // A done pulse on a boundary defers the swap to the next boundary.
                    if (boundary && (repeat_count != 16'hFFFF))
                        repeat_count <= repeat_count + 16'd1;
                    if (wr_frame_done)
                        state <= PENDING;
                end
                default: begin
                    if (boundary) begin
                        state         <= FILL;
                        frame_swapped <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign visible  = (hc < H_LIM) && (vc < V_LIM);
    assign tile_col = hc / TILE;
    assign tile_row = vc / TILE;
    assign tile_lin = {10'd0, tile_row} * COLS_W + {10'd0, tile_col};
    assign rd_addr_next = visible ? ADDR_W'(tile_lin) : '0;

    // Buffer select is captured post-swap so pixel (0,0) of a new frame reads the new front.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q      <= '0;
            vis_q          <= 1'b0;
            sel_q          <= 1'b0;
            vis_q1         <= 1'b0;
            sel_q1         <= 1'b0;
            pixel_valid    <= 1'b0;
            pixel_data_out <= '0;
        end else begin
            rd_addr_q      <= rd_addr_next;
            vis_q          <= visible;
            sel_q          <= front_next;
            vis_q1         <= vis_q;
            sel_q1         <= sel_q;
            pixel_valid    <= vis_q1;
            pixel_data_out <= vis_q1 ? (sel_q1 ? rd1 : rd0) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we0)
            mem0[wr_addr] <= wr_data;
        else
            rd0 <= mem0[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (we1)
            mem1[wr_addr] <= wr_data;
        else
            rd1 <= mem1[rd_addr_q];
    end

endmodule

// File: tb/tb_tiled_frame_buffer.sv
// Directed self-checking bench for tiled_frame_buffer with default 640x480, 20-pixel tiles.
module tb_tiled_frame_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_frame_done;
    logic       wr_ready;
    logic [7:0] pixel_data_out;
    logic       pixel_valid;
    logic       front_sel;
    logic       frame_swapped;
    logic [15:0] repeat_count;

    int checks = 0;
    int errors = 0;

    tiled_frame_buffer #(
        .HPIXELS(640),
        .VPIXELS(480),
        .BLOCK_SIZE(20),
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hc(hc),
        .vc(vc),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_frame_done(wr_frame_done),
        .wr_ready(wr_ready),
        .pixel_data_out(pixel_data_out),
        .pixel_valid(pixel_valid),
        .front_sel(front_sel),
        .frame_swapped(frame_swapped),
        .repeat_count(repeat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hc = 10'd700;
        vc = 10'd500;
        wr_en = 1'b0;
        wr_frame_done = 1'b0;
    endtask

    task automatic pos(input int h, input int v);
        hc = 10'(h);
        vc = 10'(v);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        idle();
        repeat (3) tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_front_sel", 32'(front_sel), 32'd0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_pixel_data", 32'(pixel_data_out), 32'd0);
        chk("rst_swapped", 32'(frame_swapped), 32'd0);
        chk("rst_repeat", 32'(repeat_count), 32'd0);
        rst = 1'b0;
        tick();

        // out-of-range write, then fill buffer 1 with addr[7:0]
        wr_en = 1'b1; wr_addr = 10'd768; wr_data = 8'h77;
        tick();
        for (int a = 0; a < 768; a++) begin
            wr_en = 1'b1;
            wr_addr = 10'(a);
            wr_data = 8'(a);
            wr_frame_done = (a == 767);
            tick();
        end
        chk("done_wr_ready_low", 32'(wr_ready), 32'd0);
        chk("done_front_hold", 32'(front_sel), 32'd0);

        // pending: writes and extra done pulse are dropped
        wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'hFF; wr_frame_done = 1'b1;
        tick();
        wr_addr = 10'd1; wr_frame_done = 1'b0;
        tick();
        idle();
        chk("pending_wr_ready", 32'(wr_ready), 32'd0);

        pos(0, 0);     tick();
        chk("swap_front", 32'(front_sel), 32'd1);
        chk("swap_pulse", 32'(frame_swapped), 32'd1);
        chk("swap_wr_ready", 32'(wr_ready), 32'd1);
        chk("swap_repeat", 32'(repeat_count), 32'd0);
        pos(45, 25);   tick();
        chk("swap_pulse_end", 32'(frame_swapped), 32'd0);
        pos(25, 0);    tick();
        chk("px00_data", 32'(pixel_data_out), 32'h00);
        chk("px00_valid", 32'(pixel_valid), 32'd1);
        pos(639, 479); tick();
        chk("px45_25_data", 32'(pixel_data_out), 32'h22);
        chk("px45_25_valid", 32'(pixel_valid), 32'd1);
        pos(640, 0);   tick();
        chk("px25_0_data", 32'(pixel_data_out), 32'h01);
        pos(700, 10);  tick();
        chk("px639_479_data", 32'(pixel_data_out), 32'hFF);
        chk("px639_479_valid", 32'(pixel_valid), 32'd1);
        pos(10, 500);  tick();
        chk("px640_valid", 32'(pixel_valid), 32'd0);
        chk("px640_data", 32'(pixel_data_out), 32'd0);
        idle();        tick();
        chk("px700_valid", 32'(pixel_valid), 32'd0);
        chk("px700_data", 32'(pixel_data_out), 32'd0);
        tick();
        chk("vc500_valid", 32'(pixel_valid), 32'd0);
        chk("vc500_data", 32'(pixel_data_out), 32'd0);

        // three boundaries with no done pulse
        for (int i = 0; i < 3; i++) begin
            pos(0, 0); tick();
            idle();    tick();
        end
        chk("rep3_count", 32'(repeat_count), 32'd3);
        chk("rep3_front", 32'(front_sel), 32'd1);
        chk("rep3_swapped", 32'(frame_swapped), 32'd0);

        // asynchronous reset while a swap is pending
        wr_frame_done = 1'b1; tick();
        wr_frame_done = 1'b0;
        chk("pre_rst_wr_ready", 32'(wr_ready), 32'd0);
        pos(45, 25);
        repeat (3) tick();
        chk("pre_rst_valid", 32'(pixel_valid), 32'd1);
        chk("pre_rst_data", 32'(pixel_data_out), 32'h22);
        #2 rst = 1'b1;
        #1;
        chk("arst_front", 32'(front_sel), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        chk("arst_valid", 32'(pixel_valid), 32'd0);
        chk("arst_data", 32'(pixel_data_out), 32'd0);
        chk("arst_repeat", 32'(repeat_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pos(0, 0); tick();
        idle();
        chk("post_rst_no_swap", 32'(front_sel), 32'd0);
        chk("post_rst_no_pulse", 32'(frame_swapped), 32'd0);
        chk("post_rst_repeat", 32'(repeat_count), 32'd1);
        tick();

        // done pulse coincident with a boundary (write goes to buffer 1)
        pos(0, 0); wr_frame_done = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hA5;
        tick();
        idle();
        chk("coin_front", 32'(front_sel), 32'd0);
        chk("coin_pulse", 32'(frame_swapped), 32'd0);
        chk("coin_repeat", 32'(repeat_count), 32'd2);
        chk("coin_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        chk("coin_hold_front", 32'(front_sel), 32'd0);
        pos(0, 0); tick();
        idle();
        chk("coin_swap_front", 32'(front_sel), 32'd1);
        chk("coin_swap_pulse", 32'(frame_swapped), 32'd1);
        chk("coin_swap_repeat", 32'(repeat_count), 32'd2);
        tick();
        chk("coin_pulse_end", 32'(frame_swapped), 32'd0);
        pos(100, 0); tick();
        pos(80, 0);  tick();
        idle();      tick();
        chk("tile5_data", 32'(pixel_data_out), 32'hA5);
        chk("tile5_valid", 32'(pixel_valid), 32'd1);
        tick();
        chk("tile4_data", 32'(pixel_data_out), 32'h04);

        // saturation of repeat_count: each held boundary cycle counts once
        pos(0, 0);
        repeat (65532) tick();
        chk("sat_fffe", 32'(repeat_count), 32'hFFFE);
        repeat (3) tick();
        chk("sat_ffff", 32'(repeat_count), 32'hFFFF);
        chk("sat_front", 32'(front_sel), 32'd1);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
